// File: rtl/motor_ramp_sequencer.sv
// motor_ramp_sequencer: tick-driven soft-start ramp for the motor drive.
// Steps the drive level 30 % -> 50 % -> 100 % with a mode-dependent dwell
// per stage, graded ramp-down on stop, and a latched emergency-stop fault.
// Optional feature macro: RAMP_DOWN_EN (graded ramp-down through DN50/DN30;
// when undefined, stop returns straight to IDLE).
module motor_ramp_sequencer #(
    parameter int unsigned TICK_DIV   = 100000000,
    parameter int unsigned FAST_DWELL = 2,
    parameter int unsigned SLOW_DWELL = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic stop,
    input  logic fast,
    input  logic slow,
    input  logic estop,
    output logic out_30,
    output logic out_50,
    output logic out_100,
    output logic busy,
    output logic fault
);

    localparam int unsigned PRE_W = $clog2(TICK_DIV);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        UP30   = 3'd1,
        UP50   = 3'd2,
        RUN100 = 3'd3,
        DN50   = 3'd4,
        DN30   = 3'd5,
        FAULT  = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic               mode_fast_q, mode_fast_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [7:0]         dwell_q, dwell_d;

    logic               tick;
    logic               stage_end;
    logic               timed_stage;
    logic [7:0]         dwell_len;

    // Prescaler wrap and end-of-stage detection for the latched mode.
    assign tick      = (pre_q == PRE_W'(TICK_DIV - 1));
    assign dwell_len = mode_fast_q ? 8'(FAST_DWELL) : 8'(SLOW_DWELL);
    assign stage_end = tick && (dwell_q == dwell_len - 8'd1);

    // State, latched mode and counters; reset drops everything to IDLE at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of its neighbours.
            state_q     <= IDLE;
            mode_fast_q <= 1'b1;
            pre_q       <= '0;
            dwell_q     <= '0;
        end else begin
            state_q     <= state_d;
            mode_fast_q <= mode_fast_d;
            pre_q       <= pre_d;
            dwell_q     <= dwell_d;
        end
    end

    // Next-state logic: estop > stop > start, then dwell expiry.
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned,
        // which would otherwise infer a latch.
        state_d     = state_q;
        mode_fast_d = mode_fast_q;
        if (estop) begin
            state_d = FAULT;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !stop && (fast ^ slow)) begin
                        state_d     = UP30;
                        mode_fast_d = fast;
                    end
                end
                UP30: begin
                    if (stop)           state_d = IDLE;
                    else if (stage_end) state_d = UP50;
                end
`ifdef RAMP_DOWN_EN
                UP50: begin
                    if (stop)           state_d = DN30;
                    else if (stage_end) state_d = RUN100;
                end
                RUN100: begin
                    if (stop)           state_d = DN50;
                end
                DN50: begin
                    if (stage_end)      state_d = DN30;
                end
                DN30: begin
                    if (stage_end)      state_d = IDLE;
                end
`else
                UP50: begin
                    if (stop)           state_d = IDLE;
                    else if (stage_end) state_d = RUN100;
                end
                RUN100: begin
                    if (stop)           state_d = IDLE;
                end
`endif
                FAULT: begin
                    if (stop)           state_d = IDLE;
                end
                default:                state_d = IDLE;
            endcase
        end
    end

    // Dwell timing runs only inside timed stages and restarts on every transition.
    always_comb begin
        timed_stage = (state_q == UP30) || (state_q == UP50)
`ifdef RAMP_DOWN_EN
                   || (state_q == DN50) || (state_q == DN30)
`endif
                   ;
        pre_d   = '0;
        dwell_d = '0;
        if (timed_stage && (state_d == state_q)) begin
            pre_d   = tick ? '0 : pre_q + PRE_W'(1);
            dwell_d = tick ? dwell_q + 8'd1 : dwell_q;
        end
    end

    // Output decode straight from the state register.
    always_comb begin
        out_30  = (state_q == UP30);
        out_50  = (state_q == UP50);
`ifdef RAMP_DOWN_EN
        out_30  = out_30 || (state_q == DN30);
        out_50  = out_50 || (state_q == DN50);
`endif
        out_100 = (state_q == RUN100);
        busy    = (state_q != IDLE) && (state_q != FAULT);
        fault   = (state_q == FAULT);
    end

endmodule

// File: tb/tb_motor_ramp_sequencer.sv
// Directed bench for motor_ramp_sequencer with TICK_DIV=4, FAST_DWELL=2,
// SLOW_DWELL=3: a fast stage lasts 8 cycles, a slow stage 12 cycles.
// Expectations follow RAMP_DOWN_EN the same way the design build does.
module tb_motor_ramp_sequencer;

    logic clk = 1'b0;
    logic reset, start, stop, fast, slow, estop;
    logic out_30, out_50, out_100, busy, fault;

    int n_tests = 0;
    int n_fail  = 0;

    // Observed vector: {out_30, out_50, out_100, busy, fault}
    localparam logic [4:0] O_IDLE = 5'b00000;
    localparam logic [4:0] O_30   = 5'b10010;
    localparam logic [4:0] O_50   = 5'b01010;
    localparam logic [4:0] O_100  = 5'b00110;
    localparam logic [4:0] O_FLT  = 5'b00001;

    motor_ramp_sequencer #(
        .TICK_DIV  (4),
        .FAST_DWELL(2),
        .SLOW_DWELL(3)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .stop   (stop),
        .fast   (fast),
        .slow   (slow),
        .estop  (estop),
        .out_30 (out_30),
        .out_50 (out_50),
        .out_100(out_100),
        .busy   (busy),
        .fault  (fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [4:0] expected);
        logic [4:0] observed;
        observed = {out_30, out_50, out_100, busy, fault};
        n_tests++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    // Check the same output vector on n consecutive cycles (at the falling edge).
    task automatic expect_for(input string tag, input logic [4:0] expected, input int n);
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s[%0d]", tag, i), expected);
            @(negedge clk);
        end
    endtask

    // One-cycle start pulse with the given mode pins.
    task automatic start_pulse(input logic f, input logic s);
        fast  = f;
        slow  = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic stop_pulse();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        fast  = 1'b0;
        slow  = 1'b0;
        estop = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_state", O_IDLE);
        reset = 1'b0;
        @(negedge clk);
        check("idle_after_reset", O_IDLE);

        // Fast ramp up, hold, then stop from RUN100.
        start_pulse(1'b1, 1'b0);
        expect_for("fast_up30", O_30, 8);
        expect_for("fast_up50", O_50, 8);
        expect_for("fast_run100", O_100, 5);
        stop_pulse();
`ifdef RAMP_DOWN_EN
        expect_for("fast_dn50", O_50, 8);
        expect_for("fast_dn30", O_30, 8);
`endif
        expect_for("fast_end_idle", O_IDLE, 2);

        // Slow ramp; mode pins flip mid-ramp and must not shorten the dwell.
        start_pulse(1'b0, 1'b1);
        fast = 1'b1;
        slow = 1'b0;
        expect_for("slow_up30", O_30, 12);
        expect_for("slow_up50", O_50, 12);
        expect_for("slow_run100", O_100, 3);
        stop_pulse();
`ifdef RAMP_DOWN_EN
        expect_for("slow_dn50", O_50, 12);
        expect_for("slow_dn30", O_30, 12);
`endif
        expect_for("slow_end_idle", O_IDLE, 2);

        // Invalid mode combinations ignore a held start.
        fast  = 1'b1;
        slow  = 1'b1;
        start = 1'b1;
        expect_for("inv_both_high", O_IDLE, 20);
        fast = 1'b0;
        slow = 1'b0;
        expect_for("inv_both_low", O_IDLE, 20);

        // stop together with start in IDLE keeps IDLE.
        fast = 1'b1;
        stop = 1'b1;
        @(negedge clk);
        check("idle_stop_start", O_IDLE);
        start = 1'b0;
        stop  = 1'b0;
        @(negedge clk);

        // Estop mid UP50, fault hold, start ignored, acknowledge with stop.
        start_pulse(1'b1, 1'b0);
        expect_for("es_up30", O_30, 8);
        expect_for("es_up50", O_50, 3);
        estop = 1'b1;
        @(negedge clk);
        check("es_fault", O_FLT);
        stop = 1'b1;
        expect_for("es_stop_while_estop", O_FLT, 3);
        estop = 1'b0;
        stop  = 1'b0;
        start = 1'b1;
        expect_for("es_start_ignored", O_FLT, 3);
        start = 1'b0;
        stop  = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("es_ack_idle", O_IDLE);
        @(negedge clk);

        // Stop coincident with the UP50 stage-end tick.
        start_pulse(1'b1, 1'b0);
        expect_for("co_up30", O_30, 8);
        expect_for("co_up50", O_50, 7);
        check("co_up50_last", O_50);
        stop_pulse();
`ifdef RAMP_DOWN_EN
        expect_for("co_dn30", O_30, 8);
`endif
        expect_for("co_idle", O_IDLE, 2);

        // Async reset late in the ramp drops outputs before the next edge.
        start_pulse(1'b1, 1'b0);
        expect_for("rst_up30", O_30, 8);
        expect_for("rst_up50", O_50, 8);
        expect_for("rst_run100", O_100, 2);
`ifdef RAMP_DOWN_EN
        stop_pulse();
        expect_for("rst_dn50", O_50, 8);
        expect_for("rst_dn30", O_30, 3);
`endif
        #2 reset = 1'b1;
        #1 check("rst_async_drop", O_IDLE);
        @(negedge clk);
        reset = 1'b0;
        expect_for("rst_needs_start", O_IDLE, 4);

        // Fresh ramp after reset must see cleared counters: full 8-cycle stage.
        start_pulse(1'b1, 1'b0);
        expect_for("post_rst_up30", O_30, 8);
        check("post_rst_up50", O_50);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/motor_ramp_sequencer.md
# motor_ramp_sequencer

Tick-driven sequencer for the motor soft-start ramp: accepts start/stop commands and a fast/slow mode selection, then steps the drive level through 30 %, 50 % and 100 % with a mode-dependent dwell per stage. It has a graded ramp-down and an emergency-stop fault state. It sits between the `ui_in` command pins and the `uo_out[2:0]` level outputs of the top level. An internal tick prescaler replaces the derived 1 Hz clock, so the block runs entirely on the system clock.

## Interface
- `TICK_DIV`, 100000000: system-clock cycles per dwell tick (1 Hz at 100 MHz). Range ≥2.
- `FAST_DWELL`, 2: ticks spent in each stage in fast mode. Range 1..255.
- `SLOW_DWELL`, 5: ticks spent in each stage in slow mode. Range 1..255.

- `clk`  in  1: system clock, rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `start`  in  1: level; request ramp-up.
- `stop`  in  1: level; request ramp-down; also acknowledges a fault.
- `fast`  in  1: fast-mode select (`ui_in[0]`).
- `slow`  in  1: slow-mode select (`ui_in[1]`).
- `estop`  in  1: emergency stop, level.
- `out_30`  out  1: 30 % drive level active.
- `out_50`  out  1: 50 % drive level active.
- `out_100`  out  1: 100 % drive level active.
- `busy`  out  1: high in any state except IDLE and FAULT.
- `fault`  out  1: high in FAULT.

## Operation
- States: IDLE, UP30, UP50, RUN100, DN50, DN30, FAULT.
- Output decode from the state register:
  - `out_30` is high in UP30 and DN30.
  - `out_50` is high in UP50 and DN50.
  - `out_100` is high in RUN100.
  - At most one level output is high at any time.
- Input priority in every state: `estop` > `stop` > `start`.
- IDLE:
  - `start`=1, `stop`=0, and exactly one of `fast`/`slow` high: go to UP30 and latch the mode.
  - Any other mode combination (both high or both low): `start` is ignored and the state stays IDLE.
  - The latched mode holds until the next IDLE exit; changing `fast`/`slow` mid-ramp has no effect.
- Dwell: D = FAST_DWELL or SLOW_DWELL according to the latched mode.
- Ramp-up: UP30 →(D ticks)→ UP50 →(D ticks)→ RUN100. RUN100 holds indefinitely.
- `stop`=1 during ramp-up or run:
  - UP30 → IDLE.
  - UP50 → DN30.
  - RUN100 → DN50.
- Ramp-down: DN50 →(D ticks)→ DN30 →(D ticks)→ IDLE.
  - `start` is ignored in DN states.
  - `stop` is redundant in DN states.
- `estop`=1 in any state → FAULT; all level outputs go low.
- FAULT exits to IDLE only on a cycle with `estop`=0 and `stop`=1. `start` is ignored in FAULT.
- Prescaler: counter `pre` of width $clog2(TICK_DIV), counting 0..TICK_DIV-1. `tick` is asserted when `pre`==TICK_DIV-1.
- Dwell counter: 8-bit `dwell`, incremented on `tick`. A stage ends on the cycle where `tick`=1 and `dwell`==D-1.
- Both `pre` and `dwell` clear on every state transition, so a stage lasts exactly D×TICK_DIV cycles.
- Both counters also hold at 0 in IDLE, RUN100 and FAULT.

## Timing
- Reset (asynchronous, immediate):
  - State = IDLE; `pre`=0; `dwell`=0; latched mode = fast.
  - All outputs 0.
- All inputs are sampled on the rising edge. The state changes on the edge after sampling, and outputs follow the state register with no added latency.
- `start` sampled high in cycle N → `out_30` and `busy` high from cycle N+1.
- Stage length is exactly D×TICK_DIV cycles; each transition edge moves exactly one level output.
- `stop` and `estop` act on the next edge regardless of tick phase. The current dwell is abandoned and the counters are cleared.
- Simultaneous events:
  - `estop` wins over everything.
  - `stop`+`start` in IDLE: stays IDLE.
  - Stage-end tick coincident with `stop` in UP50: go to DN30, not RUN100.
- Reset asserted mid-ramp: outputs drop asynchronously. After reset deasserts, a fresh `start` is required.
- Inputs are assumed synchronous to `clk`; synchronizers live at top level.

## Configuration
- `RAMP_DOWN_EN` defined:
  - Graded ramp-down as described.
  - DN50 and DN30 are reachable.
- `RAMP_DOWN_EN` undefined:
  - `stop` in UP30, UP50 or RUN100 → IDLE on the next edge.
  - DN states and their decode are not synthesized.
  - All other behaviour is unchanged.

## Test plan
All scenarios use TICK_DIV=4, FAST_DWELL=2, SLOW_DWELL=3, with `RAMP_DOWN_EN` defined unless stated.
- Fast ramp: `fast`=1 with a `start` pulse → `out_30` high 8 cycles, then `out_50` high 8 cycles, then `out_100` held; `busy`=1 throughout.
- Slow ramp then stop in RUN100: `slow`=1 → 12/12 cycles up. `stop` pulse → `out_50` 12 cycles, `out_30` 12 cycles, then IDLE with all outputs 0 and `busy`=0.
- Invalid mode: `fast`=`slow`=1 or both 0, with `start` held 20 cycles → remains IDLE, all outputs 0.
- Estop mid UP50:
  - `estop`=1 → next cycle all levels 0, `fault`=1.
  - `stop`=1 while `estop`=1 → stays FAULT.
  - `estop`=0 and `stop`=1 → IDLE.
- Stop coincident with UP50 stage-end tick → DN30 (`out_30`, 8 cycles), `out_100` never asserted. Async reset asserted mid-DN30 → outputs 0 immediately.
- `RAMP_DOWN_EN` undefined: `stop` in RUN100 → IDLE next cycle, all outputs 0.
